// File: rtl/mdu_unit.sv
`timescale 1ns / 1ps
// mdu_unit: EX-stage multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run as multi-cycle operations on operands latched at issue.
// MTHI/MTLO write HI/LO directly, and MFHI/MFLO read through rd_data.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low; clears all state
//   start    issue pulse, sampled together with op, SrcA and SrcB
//   op       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//   SrcA     operand A (dividend / MT source)
//   SrcB     operand B (divisor)
//   busy     operation in flight (registered)
//   hi, lo   HI / LO registers
//   rd_data  combinational: op==MFHI ? hi : lo
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic              busy_q;
   logic [31:0]       hi_q, lo_q;
   logic [31:0]       a_q, b_q;
   logic              sgn_q;

   logic [63:0] mul_a, mul_b, prod;
   logic        a_neg, b_neg, div_zero;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

   // Result datapath works purely on the latched operands; it is consumed only on the
   // final cycle of an operation.
   always_comb begin
      mul_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      mul_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod  = mul_a * mul_b;

      // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
      a_neg    = sgn_q & a_q[31];
      b_neg    = sgn_q & b_q[31];
      a_mag    = a_neg ? (~a_q + 32'd1) : a_q;
      b_mag    = b_neg ? (~b_q + 32'd1) : b_q;
      div_zero = (b_q == 32'd0);
      q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
      r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
      quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  case (op)
                     3'd0, 3'd1: begin
                        a_q     <= SrcA;
                        b_q     <= SrcB;
                        sgn_q   <= (op == 3'd0);
                        cnt_q   <= CntW'(MULT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= StMul;
                     end
                     3'd2, 3'd3: begin
                        a_q     <= SrcA;
                        b_q     <= SrcB;
                        sgn_q   <= (op == 3'd2);
                        cnt_q   <= CntW'(DIV_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= StDiv;
                     end
                     3'd4:    hi_q <= SrcA;
                     3'd5:    lo_q <= SrcA;
                     default: ;  // MFHI/MFLO are served by rd_data alone
                  endcase
               end
            end
            StMul, StDiv: begin
               // start is ignored here; the hazard unit stalls the issuing instruction.
               if (cnt_q > CntW'(1)) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
                  if (state_q == StMul) begin
                     hi_q <= prod[63:32];
                     lo_q <= prod[31:0];
                  end else if (!div_zero) begin
                     hi_q <= rem;
                     lo_q <= quot;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy    = busy_q;
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign rd_data = (op == 3'd6) ? hi_q : lo_q;

endmodule
